// File: rtl/clock_seq_pkg.sv
// ============================================================================
//  Module      : clock_seq_pkg
//  Description : Shared types and constants for the CPU clock sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package clock_seq_pkg;

  // Sequencer state; the encoding is visible on state_o.
  typedef enum logic [1:0] {
    RESET = 2'd0,
    RUN   = 2'd1,
    BREAK = 2'd2,
    HALT  = 2'd3
  } seq_state_t;

  // Width of the completed-cycle counter.
  localparam int CYC_W = 32;

endpackage

`default_nettype wire

// File: rtl/clock_phase_gen.sv
// ============================================================================
//  Module      : clock_phase_gen
//  Description : Generates one CPU clock phase pair from the system clock.
//                A cycle is DIV clocks HIGH followed by DIV clocks LOW. Once
//                started, a cycle always runs to completion unless clr is
//                asserted; en is only consulted when idle or at a cycle end.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module clock_phase_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic clr,
  output logic cpu_clk,
  output logic cpu_iclk,
  output logic cyc_end
);

  localparam int            C_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(DIV - 1);

  logic [C_CNT_W-1:0] r_cnt;
  logic               r_busy;
  logic               r_clk;
  logic               r_iclk;

  // Half-cycle counter and phase toggle; both clock outputs are registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_clk  <= 1'b0;
      r_iclk <= 1'b1;
    end else if (clr) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_clk  <= 1'b0;
      r_iclk <= 1'b1;
    end else if (!r_busy) begin
      // Idle sits in the LOW phase; a request starts a HIGH half immediately.
      if (en) begin
        r_busy <= 1'b1;
        r_clk  <= 1'b1;
        r_iclk <= 1'b0;
        r_cnt  <= '0;
      end
    end else if (r_cnt != C_LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
      if (r_clk) begin
        r_clk  <= 1'b0;
        r_iclk <= 1'b1;
      end else if (en) begin
        // Back-to-back cycle: go straight into the next HIGH half.
        r_clk  <= 1'b1;
        r_iclk <= 1'b0;
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  assign cpu_clk  = r_clk;
  assign cpu_iclk = r_iclk;
  // High for the last system clock of the LOW half.
  assign cyc_end  = r_busy && !r_clk && (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/clock_sequencer.sv
// ============================================================================
//  Module      : clock_sequencer
//  Description : Drives the CPU core clk/iclk pair, reset and ctrlen, and
//                implements run / break / single-step / halt from the core's
//                brk and hlt outputs. Optional feature macro CYCLE_COUNT_EN
//                builds the completed-cycle counter; without it cycle_cnt is 0.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module clock_sequencer
  import clock_seq_pkg::*;
#(
  parameter int DIV       = 2,
  parameter int RST_CYC   = 4,
  parameter int START_RUN = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ext_rst,
  input  logic             cont,
  input  logic             step,
  input  logic             brk,
  input  logic             hlt,
  output logic             cpu_clk,
  output logic             cpu_iclk,
  output logic             cpu_rst,
  output logic             ctrlen,
  output logic [1:0]       state_o,
  output logic [CYC_W-1:0] cycle_cnt
);

  localparam int                C_RST_W    = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [C_RST_W-1:0] C_RST_LAST = C_RST_W'(RST_CYC - 1);

  seq_state_t          r_state;
  seq_state_t          w_next;
  logic                r_stepping;
  logic                w_stepping_next;
  logic                w_en;
  logic                w_cyc_end;
  logic                r_cont_d;
  logic                r_step_d;
  logic                w_cont_rise;
  logic                w_step_rise;
  logic [C_RST_W-1:0]  r_rst_cnt;
  logic                r_cpu_rst;
  logic                r_ctrlen;

  clock_phase_gen #(
    .DIV (DIV)
  ) u_phase (
    .clk      (clk),
    .rstn     (rstn),
    .en       (w_en),
    .clr      (ext_rst),
    .cpu_clk  (cpu_clk),
    .cpu_iclk (cpu_iclk),
    .cyc_end  (w_cyc_end)
  );

  // Edge detectors run in every state so an edge is consumed, never queued.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cont_d <= 1'b0;
      r_step_d <= 1'b0;
    end else begin
      r_cont_d <= cont;
      r_step_d <= step;
    end
  end

  assign w_cont_rise = cont && !r_cont_d;
  assign w_step_rise = step && !r_step_d;

  // Next state, step flag and the phase generator's cycle request.
  always_comb begin
    w_next          = r_state;
    w_stepping_next = r_stepping;
    w_en            = 1'b0;
    unique case (r_state)
      RESET: begin
        w_en = 1'b1;
        if (w_cyc_end && (r_rst_cnt == C_RST_LAST)) begin
          w_next = (START_RUN != 0) ? RUN : BREAK;
          w_en   = (START_RUN != 0);
        end
      end
      RUN: begin
        w_en = 1'b1;
        if (w_cyc_end) begin
          if (hlt) begin
            w_next = HALT;
            w_en   = 1'b0;
          end else if (brk) begin
            w_next = BREAK;
            w_en   = 1'b0;
          end
        end
      end
      BREAK: begin
        if (r_stepping) begin
          // Exactly one cycle: no further request; hlt at its end wins.
          if (w_cyc_end) begin
            w_stepping_next = 1'b0;
            if (hlt) begin
              w_next = HALT;
            end
          end
        end else if (w_cont_rise) begin
          // cont beats a simultaneous step; the HIGH half starts this edge.
          w_next = RUN;
          w_en   = 1'b1;
        end else if (w_step_rise) begin
          w_stepping_next = 1'b1;
          w_en            = 1'b1;
        end
      end
      HALT: begin
        w_next = HALT;
      end
      default: begin
        w_next = RESET;
      end
    endcase
    if (ext_rst) begin
      w_next          = RESET;
      w_stepping_next = 1'b0;
      w_en            = 1'b0;
    end
  end

  // State register plus registered reset and control-enable outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= RESET;
      r_stepping <= 1'b0;
      r_cpu_rst  <= 1'b1;
      r_ctrlen   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_stepping <= w_stepping_next;
      r_cpu_rst  <= (w_next == RESET);
      r_ctrlen   <= (w_next == RUN) || (w_next == BREAK);
    end
  end

  // Counts full CPU cycles spent in RESET; held at zero while ext_rst is high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rst_cnt <= '0;
    end else if (ext_rst) begin
      r_rst_cnt <= '0;
    end else if ((r_state == RESET) && w_cyc_end) begin
      r_rst_cnt <= (r_rst_cnt == C_RST_LAST) ? '0 : r_rst_cnt + 1'b1;
    end
  end

`ifdef CYCLE_COUNT_EN
  logic [CYC_W-1:0] r_cycle_cnt;

  // Completed cycles in RUN or during a single step; wraps naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cycle_cnt <= '0;
    end else if (ext_rst) begin
      r_cycle_cnt <= '0;
    end else if (w_cyc_end && ((r_state == RUN) || r_stepping)) begin
      r_cycle_cnt <= r_cycle_cnt + 1'b1;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
`else
  assign cycle_cnt = '0;
`endif

  assign cpu_rst = r_cpu_rst;
  assign ctrlen  = r_ctrlen;
  assign state_o = r_state;

endmodule

`default_nettype wire
